// File: rtl/noc_pkg.sv
// Shared NoC helpers: beat width, minimum receive-FIFO depth and channel slicing.
package noc_pkg;

  localparam int unsigned NOC_A_W    = 3;
  localparam int unsigned NOC_D_W    = 32;
  localparam int unsigned NOC_BEAT_W = NOC_A_W + NOC_D_W;

  function automatic int unsigned beat_w(input int unsigned a_w, input int unsigned d_w);
    return a_w + d_w;
  endfunction

  // Depth needed to absorb 2*HR in-flight beats plus one cycle of slack each way.
  function automatic int unsigned min_fd(input int unsigned hr);
    return 2 * hr + 2;
  endfunction

  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned bw);
    return ch * bw;
  endfunction

endpackage

// File: rtl/bft_edge_fifo.sv
// Single-channel first-word-fall-through FIFO with occupancy count; head reads as zero when empty.
module bft_edge_fifo #(
  parameter int unsigned W  = 36,
  parameter int unsigned FD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout_c,
  output logic                       empty_c,
  output logic [$clog2(FD+1)-1:0]    count
);

  localparam int unsigned AW = $clog2(FD);
  localparam int unsigned CW = $clog2(FD+1);

  logic [W-1:0]  mem [FD];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(FD));
  assign empty_c = (count == '0);
  assign do_pop  = ce & pop & ~empty_c;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push = ce & push & (~full | do_pop);
  assign dout_c  = empty_c ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bft_edge_pipe.sv
// Backpressure-correct N-channel boundary pipeline: HR forward/ready stages plus per-channel receive FIFO.
// Optional protocol/overflow checker enabled by defining BFT_EDGE_CHECK_EN.
module bft_edge_pipe
  import noc_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned A_W = NOC_A_W,
  parameter int unsigned D_W = NOC_D_W,
  parameter int unsigned HR  = 1,
  parameter int unsigned FD  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [(A_W+D_W)*N-1:0] s_data,
  input  logic [N-1:0]           s_valid,
  input  logic [N-1:0]           s_last,
  output logic [N-1:0]           s_ready,
  output logic [(A_W+D_W)*N-1:0] m_data,
  output logic [N-1:0]           m_valid,
  output logic [N-1:0]           m_last,
  input  logic [N-1:0]           m_ready,
  output logic [N-1:0]           err
);

  localparam int unsigned BW = beat_w(A_W, D_W);
  localparam int unsigned CW = $clog2(FD+1);

  if (HR < 1) begin : g_hr_chk
    $error("bft_edge_pipe: HR must be at least 1");
  end
  if (FD < min_fd(HR)) begin : g_fd_min_chk
    $error("bft_edge_pipe: FD must be at least 2*HR+2");
  end
  if ((FD & (FD - 1)) != 0) begin : g_fd_pow2_chk
    $error("bft_edge_pipe: FD must be a power of two");
  end

  logic [N-1:0]    fwd_v [HR];
  logic [N-1:0]    fwd_l [HR];
  logic [BW*N-1:0] fwd_d [HR];
  logic [N-1:0]    rdy_q [HR];
  logic [N-1:0]    rdy_raw;
  logic [N-1:0]    emp;
  logic [N-1:0]    pop;
  logic [CW-1:0]   cnt  [N];
  logic [BW:0]     head [N];

  assign s_ready = rdy_q[HR-1] & {N{ce}};
  assign m_valid = ~emp & {N{ce}};
  assign pop     = m_valid & m_ready;

  // Keep ready high only while the FIFO can still take every beat already in flight.
  always_comb begin
    rdy_raw = '0;
    for (int i = 0; i < int'(N); i++) begin
      rdy_raw[i] = (CW'(FD) - cnt[i]) > CW'(2 * HR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(HR); k++) begin
        fwd_v[k] <= '0;
        fwd_l[k] <= '0;
        fwd_d[k] <= '0;
        rdy_q[k] <= '0;
      end
    end else if (ce) begin
      fwd_v[0] <= s_valid & s_ready;
      fwd_l[0] <= s_last;
      fwd_d[0] <= s_data;
      rdy_q[0] <= rdy_raw;
      for (int k = 1; k < int'(HR); k++) begin
        fwd_v[k] <= fwd_v[k-1];
        fwd_l[k] <= fwd_l[k-1];
        fwd_d[k] <= fwd_d[k-1];
        rdy_q[k] <= rdy_q[k-1];
      end
    end
  end

  for (genvar i = 0; i < int'(N); i++) begin : g_ch
    bft_edge_fifo #(
      .W  (BW + 1),
      .FD (FD)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .ce      (ce),
      .push    (fwd_v[HR-1][i]),
      .din     ({fwd_l[HR-1][i], fwd_d[HR-1][ch_lsb(i, BW) +: BW]}),
      .pop     (pop[i]),
      .dout_c  (head[i]),
      .empty_c (emp[i]),
      .count   (cnt[i])
    );

    assign m_last[i]                   = head[i][BW];
    assign m_data[ch_lsb(i, BW) +: BW] = head[i][BW-1:0];
  end

`ifdef BFT_EDGE_CHECK_EN
  logic [N-1:0] pend_q;
  logic [N-1:0] err_q;
  logic [N-1:0] ovf;

  always_comb begin
    ovf = '0;
    for (int i = 0; i < int'(N); i++) begin
      ovf[i] = fwd_v[HR-1][i] & (cnt[i] == CW'(FD)) & ~pop[i];
    end
  end

  // pend_q marks a beat offered but not taken; dropping valid afterwards is a withdrawal.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      err_q  <= '0;
    end else if (ce) begin
      pend_q <= s_valid & ~s_ready;
      err_q  <= err_q | ovf | (pend_q & ~s_valid);
    end
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_bft_edge_pipe.sv
// Directed self-checking bench for bft_edge_pipe (N=4, HR=2, FD=8).
module tb_bft_edge_pipe;

  localparam int unsigned N   = 4;
  localparam int unsigned A_W = 3;
  localparam int unsigned D_W = 32;
  localparam int unsigned HR  = 2;
  localparam int unsigned FD  = 8;
  localparam int unsigned BW  = A_W + D_W;
  localparam int          OFS = 8;

`ifdef BFT_EDGE_CHECK_EN
  localparam logic [3:0] EXP_ERR = 4'b0010;
`else
  localparam logic [3:0] EXP_ERR = 4'b0000;
`endif

  logic            clk;
  logic            rst;
  logic            ce;
  logic [BW*N-1:0] s_data;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_last;
  logic [N-1:0]    s_ready;
  logic [BW*N-1:0] m_data;
  logic [N-1:0]    m_valid;
  logic [N-1:0]    m_last;
  logic [N-1:0]    m_ready;
  logic [N-1:0]    err;

  int n_checks = 0;
  int n_errors = 0;

  bft_edge_pipe #(.N(N), .A_W(A_W), .D_W(D_W), .HR(HR), .FD(FD)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    sv;
    logic [3:0]    sl;
    logic [BW-1:0] d0;
    logic [3:0]    exp_srdy;
    logic [3:0]    exp_mv;
    logic [3:0]    exp_ml;
    logic [BW-1:0] exp_d0;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] beat_d(input int k);
    return {3'(k), 32'hA000_0000 + 32'(k)};
  endfunction

  function automatic logic beat_l(input int k);
    return (k % 10) == 9;
  endfunction

  int            cnt_h [1024];
  bit            acc_h [1024];
  bit            pop_h [1024];
  logic [159:0]  exp_w;
  logic [BW-1:0] seg;

  initial begin
    rst = 1'b1; ce = 1'b1; s_data = '0; s_valid = '0; s_last = '0; m_ready = '1;
    for (int r = 0; r < 16; r++) begin
      tbl[r] = '{sv: 4'h0, sl: 4'h0, d0: '0, exp_srdy: (r < 2) ? 4'h0 : 4'hF,
                 exp_mv: 4'h0, exp_ml: 4'h0, exp_d0: '0};
    end
    tbl[10].sv = 4'b0001; tbl[10].sl = 4'b0001; tbl[10].d0 = 35'h5_DEADBEEF;
    tbl[13].exp_mv = 4'b0001; tbl[13].exp_ml = 4'b0001; tbl[13].exp_d0 = 35'h5_DEADBEEF;

    repeat (3) tick();
    rst = 1'b0;

    // Reset release and single beat, one row per cycle starting at the first low-rst cycle.
    for (int r = 0; r < 16; r++) begin
      s_valid = tbl[r].sv;
      s_last  = tbl[r].sl;
      s_data  = '0;
      s_data[BW-1:0] = tbl[r].d0;
      #1;
      chk($sformatf("tbl%0d s_ready", r), 160'(s_ready), 160'(tbl[r].exp_srdy));
      chk($sformatf("tbl%0d m_valid", r), 160'(m_valid), 160'(tbl[r].exp_mv));
      chk($sformatf("tbl%0d m_last", r), 160'(m_last), 160'(tbl[r].exp_ml));
      chk($sformatf("tbl%0d m_data", r), 160'(m_data), 160'(tbl[r].exp_d0));
      chk($sformatf("tbl%0d err", r), 160'(err), 160'(0));
      tick();
    end
    s_valid = '0; s_last = '0; s_data = '0;

    // 100-beat stream on ch0 with a downstream stall and a ce gap, checked against an occupancy model.
    begin
      int e, sent, rx;
      bit ce_v, mr0, exp_r, exp_mv, acc, pp;
      e = 0; sent = 0; rx = 0;
      for (int i = 0; i < 1024; i++) begin
        cnt_h[i] = 0; acc_h[i] = 1'b0; pop_h[i] = 1'b0;
      end
      for (int w = 0; w < 600; w++) begin
        ce_v = !(w >= 70 && w < 75);
        mr0  = !(w >= 20 && w <= 40);
        ce = ce_v;
        m_ready = {3'b111, mr0};
        s_valid = {3'b000, 1'(sent < 100)};
        s_data  = '0;
        s_data[BW-1:0] = (sent < 100) ? beat_d(sent) : '0;
        s_last  = {3'b000, (sent < 100) ? beat_l(sent) : 1'b0};
        #1;
        if (ce_v) begin
          if (e > 0) begin
            cnt_h[e+OFS] = cnt_h[e-1+OFS] + int'(acc_h[e-1-int'(HR)+OFS]) - int'(pop_h[e-1+OFS]);
          end
          exp_r  = cnt_h[e-int'(HR)+OFS] < int'(FD - 2*HR);
          exp_mv = cnt_h[e+OFS] > 0;
          chk($sformatf("stream w%0d s_ready", w), 160'(s_ready), 160'({3'b111, exp_r}));
          chk($sformatf("stream w%0d m_valid", w), 160'(m_valid), 160'({3'b000, exp_mv}));
          acc = (sent < 100) && exp_r;
          pp  = exp_mv && mr0;
          acc_h[e+OFS] = acc;
          pop_h[e+OFS] = pp;
          if (pp) begin
            chk($sformatf("stream beat%0d data", rx), 160'(m_data[BW-1:0]), 160'(beat_d(rx)));
            chk($sformatf("stream beat%0d last", rx), 160'(m_last[0]), 160'(beat_l(rx)));
            rx++;
          end
          if (acc) sent++;
          e++;
        end else begin
          chk($sformatf("ce_gap w%0d s_ready", w), 160'(s_ready), 160'(0));
          chk($sformatf("ce_gap w%0d m_valid", w), 160'(m_valid), 160'(0));
        end
        tick();
        if (rx == 100) break;
      end
      chk("stream beats delivered", 160'(rx), 160'(100));
      chk("stream err", 160'(err), 160'(0));
    end

    ce = 1'b1; m_ready = '1; s_valid = '0; s_last = '0; s_data = '0;
    repeat (3) tick();
    chk("drain m_valid", 160'(m_valid), 160'(0));

    // Three beats buffered on ch2, then reset: they must never appear.
    m_ready = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      s_valid = 4'b0100;
      s_last  = {1'b0, 1'(k == 2), 2'b00};
      s_data  = '0;
      s_data[2*BW +: BW] = {3'h2, 32'h1234_0000 + 32'(k)};
      #1;
      chk($sformatf("buf%0d s_ready", k), 160'(s_ready[2]), 160'(1));
      tick();
    end
    s_valid = '0; s_last = '0; s_data = '0;
    repeat (5) tick();
    chk("buffered m_valid", 160'(m_valid), 160'(4'b0100));
    seg = m_data[2*BW +: BW];
    chk("buffered head data", 160'(seg), 160'({3'h2, 32'h1234_0000}));
    chk("buffered head last", 160'(m_last), 160'(0));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_valid = 4'b0010;
    #1;
    chk("post-rst s_ready", 160'(s_ready), 160'(0));
    chk("post-rst m_valid", 160'(m_valid), 160'(0));
    chk("post-rst m_last", 160'(m_last), 160'(0));
    chk("post-rst m_data", 160'(m_data), 160'(0));
    chk("post-rst err", 160'(err), 160'(0));
    tick();
    // Withdraw the unaccepted ch1 beat while s_ready is still low.
    s_valid = '0;
    chk("withdraw s_ready c1", 160'(s_ready), 160'(0));
    tick();
    m_ready = '1;
    chk("withdraw s_ready c2", 160'(s_ready), 160'(4'hF));
    chk("withdraw err c2", 160'(err), 160'(EXP_ERR));
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("discard m_valid c%0d", k + 3), 160'(m_valid), 160'(0));
      chk($sformatf("err hold c%0d", k + 3), 160'(err), 160'(EXP_ERR));
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("final rst err", 160'(err), 160'(0));
    chk("final rst s_ready", 160'(s_ready), 160'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
